// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and call/return controller with local stack depth tracking
module pc_sequencer #(
  parameter int PC_W = 8,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC = 0,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            is_jump,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] ret_addr,
  output logic [PC_W-1:0] pc,
  output logic            fetch_en,
  output logic            push,
  output logic            pop,
  output logic [PC_W-1:0] stack_pc,
  output logic [DW-1:0]   depth,
  output logic [1:0]      err
);
  typedef enum logic [1:0] {RUN, POP, ERR} state_t;
  state_t state, state_n;
  logic [PC_W-1:0] pc_n, stack_pc_n;
  logic [DW-1:0] depth_n;
  logic [1:0] err_n;
  logic fetch_n, push_n, pop_n;
  // next-state and next-output decision; every output is registered below
  always_comb begin
    state_n = state;
    pc_n = pc;
    stack_pc_n = stack_pc;
    depth_n = depth;
    err_n = err;
    fetch_n = fetch_en;
    push_n = 1'b0;
    pop_n = 1'b0;
    case (state)
      RUN: if (!stall) begin
        if (is_ret) begin
          state_n = depth == '0 ? ERR : POP;
          err_n = depth == '0 ? 2'b10 : err;
          pop_n = depth != '0;
          fetch_n = 1'b0;
        end else if (is_call) begin
          if (depth == DW'(STACK_DEPTH)) begin
            state_n = ERR;
            err_n = 2'b01;
            fetch_n = 1'b0;
          end else begin
            push_n = 1'b1;
            stack_pc_n = pc + PC_W'(1);
            pc_n = target;
            depth_n = depth + DW'(1);
          end
        end else begin
          pc_n = is_jump ? target : pc + PC_W'(1);
        end
      end
      POP: begin
        state_n = RUN;
        pc_n = ret_addr;
        depth_n = depth - DW'(1);
        fetch_n = 1'b1;
      end
      default: fetch_n = 1'b0;
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc <= PC_W'(RESET_PC);
      stack_pc <= '0;
      depth <= '0;
      err <= 2'b00;
      fetch_en <= 1'b1;
      push <= 1'b0;
      pop <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      stack_pc <= stack_pc_n;
      depth <= depth_n;
      err <= err_n;
      fetch_en <= fetch_n;
      push <= push_n;
      pop <= pop_n;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk = 0, reset = 1, stall = 0, is_call = 0, is_ret = 0, is_jump = 0;
  logic [7:0] target = 0, ret_addr = 0, pc, stack_pc;
  logic fetch_en, push, pop;
  logic [3:0] depth;
  logic [1:0] err;
  int vectors = 0, errors = 0;

  pc_sequencer dut (.clk(clk), .reset(reset), .stall(stall), .is_call(is_call), .is_ret(is_ret),
    .is_jump(is_jump), .target(target), .ret_addr(ret_addr), .pc(pc), .fetch_en(fetch_en),
    .push(push), .pop(pop), .stack_pc(stack_pc), .depth(depth), .err(err));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    stall = 0; is_call = 0; is_ret = 0; is_jump = 0;
  endtask

  task automatic do_reset();
    clear_flags();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
    vectors++; if ({push, pop} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {push, pop}); end
    vectors++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", depth); end
    vectors++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", err); end
    vectors++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL reset_fetch got %b want 1", fetch_en); end
    vectors++; if (stack_pc !== 8'd0) begin errors++; $display("FAIL reset_stack_pc got %0d want 0", stack_pc); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++; if (pc !== 8'(i)) begin errors++; $display("FAIL seq_pc got %0d want %0d", pc, i); end
      vectors++; if ({push, pop, fetch_en} !== 3'b001 || depth !== 4'd0) begin errors++; $display("FAIL seq_ctrl got push/pop/fetch %b depth %0d want 001 depth 0", {push, pop, fetch_en}, depth); end
    end
  endtask

  task automatic test_call_ret();
    is_jump = 1; target = 8'd34; step(); clear_flags();
    vectors++; if (pc !== 8'd34) begin errors++; $display("FAIL jump_pc got %0d want 34", pc); end
    is_call = 1; target = 8'd100; step(); clear_flags();
    vectors++; if ({push, pop} !== 2'b10 || stack_pc !== 8'd35) begin errors++; $display("FAIL call_push got push/pop %b stack_pc %0d want 10 35", {push, pop}, stack_pc); end
    vectors++; if (pc !== 8'd100 || depth !== 4'd1) begin errors++; $display("FAIL call_pc got pc %0d depth %0d want 100 1", pc, depth); end
    is_ret = 1; step(); clear_flags();
    vectors++; if ({push, pop, fetch_en} !== 3'b010 || pc !== 8'd100) begin errors++; $display("FAIL ret_pop got push/pop/fetch %b pc %0d want 010 100", {push, pop, fetch_en}, pc); end
    ret_addr = 8'd35; step();
    vectors++; if (pc !== 8'd35 || depth !== 4'd0 || {pop, fetch_en} !== 2'b01) begin errors++; $display("FAIL ret_done got pc %0d depth %0d pop/fetch %b want 35 0 01", pc, depth, {pop, fetch_en}); end
    step();
    vectors++; if (pc !== 8'd36) begin errors++; $display("FAIL after_ret_pc got %0d want 36", pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      is_call = 1; target = 8'(10 + k); step();
      vectors++; if (push !== 1'b1 || stack_pc !== 8'(k == 0 ? 1 : 10 + k) || pc !== 8'(10 + k) || depth !== 4'(k + 1)) begin errors++; $display("FAIL b2b_call%0d got push %b stack_pc %0d pc %0d depth %0d want 1 %0d %0d %0d", k, push, stack_pc, pc, depth, k == 0 ? 1 : 10 + k, 10 + k, k + 1); end
    end
    target = 8'd50; step(); clear_flags();
    vectors++; if (err !== 2'b01 || fetch_en !== 1'b0 || push !== 1'b0 || pc !== 8'd17 || depth !== 4'd8) begin errors++; $display("FAIL overflow got err %b fetch %b push %b pc %0d depth %0d want 01 0 0 17 8", err, fetch_en, push, pc, depth); end
    is_jump = 1; target = 8'd3; step(); step(); clear_flags();
    vectors++; if (err !== 2'b01 || fetch_en !== 1'b0 || pc !== 8'd17) begin errors++; $display("FAIL overflow_sticky got err %b fetch %b pc %0d want 01 0 17", err, fetch_en, pc); end
    do_reset();
    vectors++; if (pc !== 8'd0 || err !== 2'b00 || depth !== 4'd0 || fetch_en !== 1'b1) begin errors++; $display("FAIL overflow_reset got pc %0d err %b depth %0d fetch %b want 0 00 0 1", pc, err, depth, fetch_en); end
    step();
    vectors++; if (pc !== 8'd1) begin errors++; $display("FAIL overflow_run got pc %0d want 1", pc); end
  endtask

  task automatic test_underflow();
    do_reset();
    is_ret = 1; step();
    vectors++; if (err !== 2'b10 || pop !== 1'b0 || pc !== 8'd0 || fetch_en !== 1'b0) begin errors++; $display("FAIL underflow got err %b pop %b pc %0d fetch %b want 10 0 0 0", err, pop, pc, fetch_en); end
    clear_flags(); step(); step();
    vectors++; if (err !== 2'b10 || pop !== 1'b0 || pc !== 8'd0) begin errors++; $display("FAIL underflow_sticky got err %b pop %b pc %0d want 10 0 0", err, pop, pc); end
  endtask

  task automatic test_wrap_stall_priority();
    do_reset();
    is_jump = 1; target = 8'd255; step(); clear_flags();
    vectors++; if (pc !== 8'd255) begin errors++; $display("FAIL wrap_setup got %0d want 255", pc); end
    step();
    vectors++; if (pc !== 8'd0) begin errors++; $display("FAIL wrap got %0d want 0", pc); end
    stall = 1; is_call = 1; target = 8'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (pc !== 8'd0 || {push, pop} !== 2'b00 || depth !== 4'd0) begin errors++; $display("FAIL stall%0d got pc %0d push/pop %b depth %0d want 0 00 0", i, pc, {push, pop}, depth); end
    end
    clear_flags(); is_call = 1; target = 8'd40; step();
    vectors++; if (pc !== 8'd40 || depth !== 4'd1 || stack_pc !== 8'd1) begin errors++; $display("FAIL prio_setup got pc %0d depth %0d stack_pc %0d want 40 1 1", pc, depth, stack_pc); end
    is_ret = 1; target = 8'd77; is_jump = 1; step(); clear_flags();
    vectors++; if ({push, pop} !== 2'b01 || pc !== 8'd40 || depth !== 4'd1 || stack_pc !== 8'd1) begin errors++; $display("FAIL prio_ret got push/pop %b pc %0d depth %0d stack_pc %0d want 01 40 1 1", {push, pop}, pc, depth, stack_pc); end
    ret_addr = 8'd1; stall = 1; step(); stall = 0;
    vectors++; if (pc !== 8'd1 || depth !== 4'd0 || pop !== 1'b0 || stack_pc !== 8'd1) begin errors++; $display("FAIL prio_done got pc %0d depth %0d pop %b stack_pc %0d want 1 0 0 1", pc, depth, pop, stack_pc); end
  endtask

  task automatic test_reset_mid_pop();
    do_reset();
    is_call = 1; target = 8'd60; step(); clear_flags();
    is_ret = 1; step(); clear_flags();
    vectors++; if (pop !== 1'b1) begin errors++; $display("FAIL midpop_setup got pop %b want 1", pop); end
    ret_addr = 8'd99; reset = 1; step(); reset = 0;
    vectors++; if (pc !== 8'd0 || pop !== 1'b0 || depth !== 4'd0 || fetch_en !== 1'b1) begin errors++; $display("FAIL midpop_reset got pc %0d pop %b depth %0d fetch %b want 0 0 0 1", pc, pop, depth, fetch_en); end
    step();
    vectors++; if (pc !== 8'd1 || pop !== 1'b0) begin errors++; $display("FAIL midpop_run got pc %0d pop %b want 1 0", pc, pop); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_ret();
    test_back_to_back();
    test_underflow();
    test_wrap_stall_priority();
    test_reset_mid_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and call/return controller for the 19-bit CPU.
- Drives the register file's return-address stack interface (push, pop, stack_pc) and consumes the popped return address.
- Decides the next PC each cycle from decode flags: sequential, jump, call or return.
- Tracks stack depth locally and traps overflow/underflow before any illegal push/pop reaches the register file.

Parameters:
- PC_W, 8, PC and address width; matches register-file stack_pc width.
- STACK_DEPTH, 8, maximum number of outstanding calls the register-file stack holds.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freeze PC and decisions for this cycle (RUN state only).
- is_call  input  1  decoded CALL in the current instruction.
- is_ret  input  1  decoded RET in the current instruction.
- is_jump  input  1  decoded unconditional jump.
- target  input  PC_W  jump/call destination.
- ret_addr  input  PC_W  register-file stack top; valid while pop=1.
- pc  output  PC_W  current program counter.
- fetch_en  output  1  PC is valid for instruction fetch this cycle.
- push  output  1  one-cycle push strobe to the register file.
- pop  output  1  one-cycle pop strobe to the register file.
- stack_pc  output  PC_W  return address presented with push.
- depth  output  clog2(STACK_DEPTH+1)  current stack occupancy.
- err  output  2  00 none, 01 overflow, 10 underflow; sticky.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk. Reset overrides everything, including mid-pop.
- Reset values: pc=RESET_PC, push=0, pop=0, stack_pc=0, depth=0, err=00, state=RUN. fetch_en=1 from the first cycle after reset deasserts.
- All outputs are registered. No combinational path from inputs to outputs.
- States: RUN, POP, ERR.
- RUN with stall=1: pc, depth and state hold; push=0, pop=0.
- RUN with stall=0: evaluate flags with fixed priority is_ret > is_call > is_jump > sequential.
  - ret, depth==0: err<=10, state<=ERR, pop stays 0.
  - ret, depth>0: pop<=1, state<=POP, fetch_en<=0, pc held.
  - call, depth==STACK_DEPTH: err<=01, state<=ERR, push stays 0.
  - call, depth<STACK_DEPTH: push<=1, stack_pc<=pc+1 (mod 2^PC_W), pc<=target, depth<=depth+1.
  - jump: pc<=target.
  - none: pc<=pc+1, wrapping 2^PC_W-1 to 0.
- Strobe width: push and pop are high for exactly one cycle per accepted event and return to 0 the next cycle unless a new event is accepted.
- Back-to-back calls: produce consecutive push pulses, each with its own stack_pc.
- POP state (1 cycle, ignores stall):
  - pop=1 and fetch_en=0 for this cycle.
  - At its closing edge: pc<=ret_addr, depth<=depth-1, pop<=0, fetch_en<=1, state<=RUN.
  - A ret can therefore be accepted again in the cycle immediately after POP.
- ERR: pc frozen, fetch_en=0, push=pop=0. err holds its code until reset.
- Simultaneous flags: only the highest-priority flag acts; lower flags are ignored that cycle.
- stack_pc holds its last pushed value when push=0.

Test Plan:
- Reset then 5 free cycles, no flags -> pc 0,1,2,3,4,5; push=pop=0; depth=0; fetch_en=1.
- At pc=34, is_call with target=100 -> next cycle push=1, stack_pc=35, pc=100, depth=1. Then is_ret -> pop=1 and fetch_en=0 for one cycle with ret_addr=35 driven; the following cycle pc=35, depth=0, fetch_en=1.
- 8 back-to-back calls to targets 10..17, then a 9th call -> eight push pulses, depth=8; 9th call gives err=01, fetch_en=0, no push; state stays ERR until reset, then pc=0 and err=00.
- is_ret with depth=0 -> err=10, pop never asserted, pc frozen.
- pc=255 with no flags -> pc=0. Stall held 3 cycles -> pc unchanged, no strobes. is_call and is_ret together with depth=1 -> ret wins: pop=1, no push.
- Reset asserted during the POP cycle -> next cycle pc=RESET_PC, pop=0, depth=0, state RUN.
